// File: rtl/uart_cfg_loader.sv
// uart_cfg_loader: receives configuration bytes over a UART line into a shadow
// buffer. Once a full set of NUM_BYTES bytes is collected it is committed to
// cfg_flat on the next vsync falling edge.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   rx              - asynchronous UART line (idle high, LSB first)
//   vsync           - synchronous frame sync; its falling edge commits a pending set
//   cfg_flat        - active configuration, byte k in bits [8k+7:8k]
//   commit          - one-cycle pulse when cfg_flat updates
//   rx_strobe/rx_byte - one-cycle pulse with each byte the UART accepts
//   sample_tick     - prescaler tick, one cycle every DIV clocks
//   frame_err       - sticky: bad stop bit (or parity) seen
//   overrun         - sticky: byte arrived while a full set was still pending
//
// Build option: define UART_CFG_PARITY_EN to expect an even-parity bit
// between the data bits and the stop bit.
module uart_cfg_loader #(
    parameter int unsigned NUM_BYTES       = 60,
    parameter int unsigned DIV             = 27,
    parameter int unsigned OVERSAMPLE      = 16,
    parameter int unsigned IDLE_RESET_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic                   vsync,
    output logic [NUM_BYTES*8-1:0] cfg_flat,
    output logic                   commit,
    output logic                   rx_strobe,
    output logic [7:0]             rx_byte,
    output logic                   sample_tick,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int unsigned PRESC_W    = $clog2(DIV);
    localparam int unsigned OS_W       = $clog2(OVERSAMPLE);
    localparam int unsigned HALF       = OVERSAMPLE / 2;
    localparam int unsigned IDX_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned IDLE_LIMIT = IDLE_RESET_BITS * OVERSAMPLE;
    localparam int unsigned IDLE_LAST  = (IDLE_LIMIT > 0) ? IDLE_LIMIT - 1 : 0;
    localparam int unsigned IDLE_W     = (IDLE_LIMIT > 0) ? $clog2(IDLE_LIMIT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_e;

    // Registers
    logic                          rx_meta_q, rx_sync_q;
    logic [PRESC_W-1:0]            presc_q, presc_d;
    logic                          tick_q, tick_d;
    rx_state_e                     state_q, state_d;
    logic [OS_W-1:0]               os_cnt_q, os_cnt_d;
    logic [2:0]                    bit_cnt_q, bit_cnt_d;
    logic [7:0]                    shift_q, shift_d;
    logic [7:0]                    byte_q, byte_d;
    logic                          strobe_q, strobe_d;
    logic                          frame_err_q, frame_err_d;
    logic                          overrun_q, overrun_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          pending_q, pending_d;
    logic [NUM_BYTES-1:0][7:0]     shadow_q, shadow_d;
    logic [NUM_BYTES-1:0][7:0]     cfg_q, cfg_d;
    logic                          commit_q, commit_d;
    logic                          vsync_prev_q;
    logic [IDLE_W-1:0]             idle_cnt_q, idle_cnt_d;
`ifdef UART_CFG_PARITY_EN
    logic                          par_bad_q, par_bad_d;
`endif

    logic accept_c;
    logic vsync_fall_c;

    // Free-running prescaler; tick_q is high in the cycle the count sits at DIV-1
    always_comb begin
        presc_d = (presc_q == PRESC_W'(DIV - 1)) ? '0 : presc_q + PRESC_W'(1);
        tick_d  = (presc_d == PRESC_W'(DIV - 1));
    end

    // UART receive FSM, advances only on prescaler ticks
    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = frame_err_q;
        accept_c    = 1'b0;
`ifdef UART_CFG_PARITY_EN
        par_bad_d   = par_bad_q;
`endif
        if (tick_q) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_sync_q) begin
                        state_d  = S_START;
                        os_cnt_d = '0;
                    end
                end
                S_START: begin
                    // Re-check the line at mid start bit to reject glitches
                    if (os_cnt_q == OS_W'(HALF - 1)) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        state_d   = rx_sync_q ? S_IDLE : S_DATA;
`ifdef UART_CFG_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                S_DATA: begin
                    if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
                        os_cnt_d  = '0;
                        shift_d   = {rx_sync_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_CFG_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
`ifdef UART_CFG_PARITY_EN
                S_PARITY: begin
                    if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
                        os_cnt_d  = '0;
                        // Even parity: data bits plus parity bit XOR to zero
                        par_bad_d = rx_sync_q ^ (^shift_q);
                        state_d   = S_STOP;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
                        os_cnt_d = '0;
`ifdef UART_CFG_PARITY_EN
                        if (rx_sync_q && !par_bad_q) begin
`else
                        if (rx_sync_q) begin
`endif
                            accept_c = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = rx_sync_q ? S_IDLE : S_WAIT_HIGH;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    // A low stop bit may be a break; hold off until the line idles
                    if (rx_sync_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Byte output pulse
    always_comb begin
        strobe_d = accept_c;
        byte_d   = accept_c ? shift_q : byte_q;
    end

    // Shadow fill, commit on vsync fall, overrun and idle resynchronisation
    always_comb begin
        idx_d        = idx_q;
        pending_d    = pending_q;
        shadow_d     = shadow_q;
        cfg_d        = cfg_q;
        commit_d     = 1'b0;
        overrun_d    = overrun_q;
        idle_cnt_d   = idle_cnt_q;
        vsync_fall_c = vsync_prev_q & ~vsync;

        // Uses pending_q, so a set completing this cycle waits for the next fall
        if (vsync_fall_c && pending_q) begin
            cfg_d     = shadow_q;
            pending_d = 1'b0;
            commit_d  = 1'b1;
        end

        if (accept_c) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                shadow_d[idx_q] = shift_q;
                if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
                    idx_d     = '0;
                    pending_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end

        // Long idle mid-set means the sender restarted; realign to byte 0
        if (IDLE_RESET_BITS != 0) begin
            if (state_q == S_IDLE && state_d == S_IDLE) begin
                if (tick_q && idle_cnt_q != IDLE_W'(IDLE_LIMIT)) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    if (idle_cnt_q == IDLE_W'(IDLE_LAST)) begin
                        idx_d = '0;
                    end
                end
            end else begin
                idle_cnt_d = '0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            presc_q      <= '0;
            tick_q       <= 1'b0;
            state_q      <= S_IDLE;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            strobe_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            cfg_q        <= '0;
            commit_q     <= 1'b0;
            vsync_prev_q <= 1'b0;
            idle_cnt_q   <= '0;
`ifdef UART_CFG_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            strobe_q     <= strobe_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            cfg_q        <= cfg_d;
            commit_q     <= commit_d;
            vsync_prev_q <= vsync;
            idle_cnt_q   <= idle_cnt_d;
`ifdef UART_CFG_PARITY_EN
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    assign cfg_flat    = cfg_q;
    assign commit      = commit_q;
    assign rx_strobe   = strobe_q;
    assign rx_byte     = byte_q;
    assign sample_tick = tick_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

endmodule
